// File: rtl/an_encoder_mul_seq.sv
// Sequential AN-code encoder: W = A * N via a shift-add over the bits of A,
// one bit per cycle, fixed latency, valid/ready handshakes on input and output.
module an_encoder_mul_seq #(
    parameter int A        = 131,
    parameter int A_BITS   = 8,
    parameter int N_BITS   = 52,
    parameter int W_BITS   = 61,
    parameter int CNT_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] N,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_BITS-1:0] W,
    output logic              busy
);

    if (W_BITS < N_BITS + A_BITS) begin : g_bad_width
        $error("an_encoder_mul_seq: W_BITS must be >= N_BITS + A_BITS");
    end
    if ((A % 2) == 0 || A <= 1) begin : g_bad_a
        $error("an_encoder_mul_seq: A must be odd and greater than 1");
    end
    if ((1 << CNT_BITS) <= A_BITS) begin : g_bad_cnt
        $error("an_encoder_mul_seq: CNT_BITS too small for A_BITS iterations");
    end

    typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(A_BITS - 1);

    state_t              state_q, state_d;
    logic [W_BITS-1:0]   acc_q, acc_d;
    logic [W_BITS-1:0]   mcand_q, mcand_d;
    logic [A_BITS-1:0]   a_sh_q, a_sh_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [W_BITS-1:0]   w_q, w_d;
    logic                out_valid_q, out_valid_d;
    logic [W_BITS-1:0]   sum;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign W         = w_q;

    // The last iteration's add must be folded into the captured result.
    assign sum = acc_q + (a_sh_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        a_sh_d      = a_sh_q;
        cnt_d       = cnt_q;
        w_d         = w_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    mcand_d = W_BITS'(N);
                    a_sh_d  = A_BITS'(A);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d   = sum;
                mcand_d = mcand_q << 1;
                a_sh_d  = a_sh_q >> 1;
                cnt_d   = cnt_q + CNT_BITS'(1);
                if (cnt_q == CNT_LAST) begin
                    w_d         = sum;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            a_sh_q      <= '0;
            cnt_q       <= '0;
            w_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            a_sh_q      <= a_sh_d;
            cnt_q       <= cnt_d;
            w_q         <= w_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_an_encoder_mul_seq.sv
// Directed self-checking bench for an_encoder_mul_seq: reset, latency, edge
// values, back-to-back accepts, backpressure, mid-operation reset, random words.
module tb_an_encoder_mul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [51:0] N = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [60:0] W;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acceptTimes[$];

    an_encoder_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .N         (N),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .W         (W),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Timestamp every accepting edge so accept spacing can be checked.
    always @(posedge clk) begin
        cyc++;
        if (in_valid && in_ready) acceptTimes.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    task automatic waitReady(input string tag);
        int n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        checkOutput({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
    endtask

    // Encode one word with out_ready high; checks latency, W and return to IDLE.
    task automatic applyStimulus(input logic [51:0] n, input logic [60:0] expW,
                                 input string tag);
        int lat = 0;
        waitReady(tag);
        out_ready = 1'b1;
        N         = n;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'd8);
        checkOutput({tag, "_W"}, 64'(W), 64'(expW));
        tick();
        checkOutput({tag, "_ovalid_drop"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_busy_drop"}, 64'(busy), 64'd0);
    endtask

    initial begin : main
        int lat;
        int nAcc;
        logic [60:0] held;
        logic [51:0] rn;
        logic [60:0] rexp;

        // Reset state, including in_ready forced low while rst is high
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_W", 64'(W), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rel_in_ready", 64'(in_ready), 64'd1);

        // N=0: in_ready drops right after accept, busy rises
        out_ready = 1'b1;
        N         = '0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("zero_in_ready_drop", 64'(in_ready), 64'd0);
        checkOutput("zero_busy", 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("zero_latency", 64'(lat), 64'd8);
        checkOutput("zero_W", 64'(W), 64'd0);
        tick();
        checkOutput("zero_busy_drop", 64'(busy), 64'd0);

        // Edge values
        applyStimulus(52'd1, 61'd131, "one");
        applyStimulus(52'hF_FFFF_FFFF_FFFF, 61'h82F_FFFF_FFFF_FF7D, "max");

        // Back-to-back with in_valid held high
        waitReady("b2b");
        acceptTimes.delete();
        out_ready = 1'b1;
        N         = 52'd1000;
        in_valid  = 1'b1;
        tick();
        N   = 52'd1001;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("b2b_W0", 64'(W), 64'd131000);
        lat = 0;
        while (acceptTimes.size() < 2 && lat < 20) begin
            tick();
            lat++;
        end
        in_valid = 1'b0;
        checkOutput("b2b_accepts", 64'(acceptTimes.size()), 64'd2);
        if (acceptTimes.size() >= 2)
            checkOutput("b2b_spacing", 64'(acceptTimes[1] - acceptTimes[0]), 64'd10);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("b2b_W1", 64'(W), 64'd131131);
        tick();

        // Backpressure: hold for 5 cycles while a new word is offered
        waitReady("bp");
        out_ready = 1'b0;
        N         = 52'd12345;
        in_valid  = 1'b1;
        tick();
        N   = 52'd999;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("bp_W", 64'(W), 64'd1617195);
        held = W;
        nAcc = acceptTimes.size();
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_ovalid_held", 64'(out_valid), 64'd1);
            checkOutput("bp_W_stable", 64'(W), 64'(held));
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("bp_no_accept", 64'(acceptTimes.size()), 64'(nAcc));
        checkOutput("bp_ovalid_drop", 64'(out_valid), 64'd0);
        checkOutput("bp_idle", 64'(in_ready), 64'd1);
        checkOutput("bp_W_kept", 64'(W), 64'd1617195);

        // Reset pulse on the 4th MUL cycle
        waitReady("mrst");
        N        = 52'd777;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("mrst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("mrst_busy", 64'(busy), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("mrst_rel_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("mrst_ovalid", 64'(out_valid), 64'd0);
        checkOutput("mrst_W", 64'(W), 64'd0);
        applyStimulus(52'd5, 61'd655, "after_rst");

        // Random words: W must be exactly 131*N
        for (int i = 0; i < 200; i++) begin
            rn   = 52'({$urandom, $urandom});
            rexp = 61'(rn) * 61'd131;
            applyStimulus(rn, rexp, "rand");
            checkOutput("rand_mod", 64'(W % 61'd131), 64'd0);
            checkOutput("rand_div", 64'(W / 61'd131), 64'(rn));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
